// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words and checks them
// against build-time constants, yielding a hardware "correct image" flag.
module nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1433724198,
    parameter int unsigned TIMEOUT_CYCLES     = 16,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_ID = 3'd1;
    localparam logic [2:0] S_RD_TS = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [31:0] WAIT_LAST = TIMEOUT_CYCLES[31:0] - 32'd1;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic        auto_pending;
    logic [31:0] wait_cnt;
    logic        go;
    logic        wait_expired;

    assign go = start || auto_pending;

    // wait_cnt holds the number of stalled cycles already seen in this read
    assign wait_expired = (TIMEOUT_CYCLES != 0) && avm_waitrequest && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (go) state_next = S_RD_ID;
            S_RD_ID: begin
                if (!avm_waitrequest)  state_next = S_RD_TS;
                else if (wait_expired) state_next = S_DONE;
            end
            S_RD_TS: begin
                if (!avm_waitrequest)  state_next = S_CHECK;
                else if (wait_expired) state_next = S_DONE;
            end
            S_CHECK: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            auto_pending <= AUTO_START;
            wait_cnt     <= 32'd0;
            pass         <= 1'b0;
            id_ok        <= 1'b0;
            ts_ok        <= 1'b0;
            timeout      <= 1'b0;
            id_value     <= 32'd0;
            ts_value     <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        auto_pending <= 1'b0;
                        wait_cnt     <= 32'd0;
                        pass         <= 1'b0;
                        id_ok        <= 1'b0;
                        ts_ok        <= 1'b0;
                        timeout      <= 1'b0;
                        id_value     <= 32'd0;
                        ts_value     <= 32'd0;
                    end
                end
                S_RD_ID: begin
                    if (!avm_waitrequest) begin
                        id_value <= avm_readdata;
                        wait_cnt <= 32'd0;
                    end else if (wait_expired) begin
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_RD_TS: begin
                    if (!avm_waitrequest) begin
                        ts_value <= avm_readdata;
                        wait_cnt <= 32'd0;
                    end else if (wait_expired) begin
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_CHECK: begin
                    id_ok <= (id_value == EXPECTED_ID);
                    ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
                    pass  <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        avm_read    = (state == S_RD_ID) || (state == S_RD_TS);
        avm_address = (state == S_RD_TS);
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
    end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Scoreboard bench for the sysid checker: directed runs push expected results,
// a monitor pops and compares them on every done pulse.
module tb_nios_system_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1433724198;
    localparam logic [31:0] TS_BAD  = 32'd1433724199;

    logic        clock;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;
    logic        pass;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    nios_system_sysid_checker dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave model: inserts 'waits' stall cycles per read, or stalls forever on address 1
    logic [31:0] id_data;
    logic [31:0] ts_data;
    logic [31:0] waits;
    logic        stuck1;
    logic [31:0] wcnt;

    always @(posedge clock or posedge reset) begin
        if (reset)                           wcnt <= 32'd0;
        else if (avm_read && avm_waitrequest) wcnt <= wcnt + 32'd1;
        else                                 wcnt <= 32'd0;
    end

    assign avm_waitrequest = avm_read && ((stuck1 && avm_address) || (wcnt < waits));
    assign avm_readdata    = avm_address ? ts_data : id_data;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        pass;
        logic        id_ok;
        logic        ts_ok;
        logic        timeout;
        logic [31:0] id;
        logic [31:0] ts;
    } exp_t;

    exp_t sb[$];

    // Monitor: one scoreboard entry per done pulse, and done never lasts two cycles
    logic prev_done = 1'b0;
    always @(negedge clock) begin
        if (done === 1'b1) begin
            check("done_single_cycle", 32'(prev_done), 32'd0);
            if (sb.size() == 0) begin
                check("done_expected", 32'd0, 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pass",     32'(pass),    32'(e.pass));
                check("id_ok",    32'(id_ok),   32'(e.id_ok));
                check("ts_ok",    32'(ts_ok),   32'(e.ts_ok));
                check("timeout",  32'(timeout), 32'(e.timeout));
                check("id_value", id_value,     e.id);
                check("ts_value", ts_value,     e.ts);
            end
        end
        prev_done <= done;
    end

    // Address and read must not move while the slave stalls
    logic stab_en = 1'b0;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;
    logic prev_addr = 1'b0;
    always @(negedge clock) begin
        if (stab_en && prev_rd && prev_wr) begin
            check("read_stable", 32'(avm_read), 32'd1);
            check("addr_stable", 32'(avm_address), 32'(prev_addr));
        end
        prev_rd   <= avm_read;
        prev_wr   <= avm_waitrequest;
        prev_addr <= avm_address;
    end

    task automatic push(input logic p, input logic i, input logic t, input logic to,
                        input logic [31:0] id, input logic [31:0] ts);
        exp_t e;
        e.pass = p; e.id_ok = i; e.ts_ok = t; e.timeout = to; e.id = id; e.ts = ts;
        sb.push_back(e);
    endtask

    // Counts negedges until done is seen; rd1 counts samples reading address 1
    task automatic run_wait(input bit hold, output int n, output int rd1);
        n = 0;
        rd1 = 0;
        do begin
            @(negedge clock);
            n++;
            if (!hold) start = 1'b0;
            if (avm_read && avm_address) rd1++;
        end while (!done && n < 300);
        check("done_seen", 32'(done), 32'd1);
    endtask

    int n;
    int rd1;
    int k;

    initial begin
        start   = 1'b0;
        reset   = 1'b1;
        id_data = 32'd0;
        ts_data = TS_GOOD;
        waits   = 32'd0;
        stuck1  = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_read",     32'(avm_read),    32'd0);
        check("rst_addr",     32'(avm_address), 32'd0);
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_done",     32'(done),        32'd0);
        check("rst_pass",     32'(pass),        32'd0);
        check("rst_timeout",  32'(timeout),     32'd0);
        check("rst_id_value", id_value,         32'd0);

        // Auto-start run, zero wait states
        push(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD);
        reset = 1'b0;
        run_wait(1'b0, n, rd1);
        check("auto_done_cycle", n, 32'd4);
        @(negedge clock);
        check("auto_busy_after", 32'(busy), 32'd0);

        // Wrong timestamp by one
        ts_data = TS_BAD;
        push(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, TS_BAD);
        start = 1'b1;
        run_wait(1'b0, n, rd1);
        check("badts_done_cycle", n, 32'd4);
        @(negedge clock);
        check("badts_done_low", 32'(done), 32'd0);
        check("badts_busy_low", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        check("idle_hold_ts", ts_value, TS_BAD);
        check("idle_hold_tsok", 32'(ts_ok), 32'd0);

        // Three wait states per read
        ts_data = TS_GOOD;
        waits   = 32'd3;
        stab_en = 1'b1;
        push(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD);
        start = 1'b1;
        run_wait(1'b0, n, rd1);
        check("wait_done_cycle", n, 32'd10);
        stab_en = 1'b0;
        waits   = 32'd0;
        @(negedge clock);

        // Timestamp read hangs: timeout after 16 cycles
        stuck1 = 1'b1;
        push(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        start = 1'b1;
        run_wait(1'b0, n, rd1);
        check("to_read_cycles", rd1, 32'd16);
        check("to_done_cycle", n, 32'd18);
        stuck1 = 1'b0;
        @(negedge clock);

        // Reset in the middle of the timestamp read
        waits   = 32'd3;
        id_data = 32'hDEADBEEF;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (!(avm_read && avm_address) && k < 50) begin
            @(negedge clock);
            k++;
        end
        check("mid_reached_rd_ts", 32'(avm_read && avm_address), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_read",     32'(avm_read), 32'd0);
        check("mid_rst_busy",     32'(busy),     32'd0);
        check("mid_rst_id_value", id_value,      32'd0);
        check("mid_rst_idok",     32'(id_ok),    32'd0);
        id_data = 32'd0;
        waits   = 32'd0;
        @(negedge clock);
        push(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD);
        reset = 1'b0;
        run_wait(1'b0, n, rd1);
        check("rerun_done_cycle", n, 32'd4);
        @(negedge clock);

        // start held high: back-to-back runs, results cleared at each run start
        push(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD);
        push(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD);
        start = 1'b1;
        run_wait(1'b1, n, rd1);
        check("b2b_first_cycle", n, 32'd4);
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!(avm_read && !avm_address) && k < 20);
        check("b2b_restart_read", 32'(avm_read), 32'd1);
        check("b2b_clear_pass",   32'(pass),     32'd0);
        check("b2b_clear_ts",     ts_value,      32'd0);
        run_wait(1'b1, n, rd1);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("b2b_idle_busy", 32'(busy), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
